inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the control unit's decode path: accepts symbolic instruction requests (mnemonic + register/immediate fields) and emits 32-bit MIPS machine words.
- Streams the words into instruction memory at consecutive word addresses.
- Used by the boot/self-test loader to build programs for the single-cycle CPU without a host assembler.
- Contains a session FSM, a word counter, an address counter and a one-entry output buffer with valid/ready backpressure.

Parameters:
- ADDR_W, 32, instruction-memory byte-address width.
- CNT_W, 10, width of the session word count; a session is at most 2^CNT_W-1 words.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that opens a session; ignored unless the FSM is in IDLE
- base_addr  in  ADDR_W  byte address of the first word; bits [1:0] are ignored (forced to 0)
- count  in  CNT_W  number of words in the session
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid and req_ready are both high
- mnem  in  5  mnemonic code (package enum)
- rs, rt, rd, shamt  in  5 each  register and shift fields
- imm  in  16  immediate or branch offset
- target  in  26  jump target field
- mem_valid  out  1  write word valid
- mem_ready  in  1  memory accepts the word
- mem_addr  out  ADDR_W  byte address of the write
- mem_wdata  out  32  encoded instruction
- busy  out  1  high whenever the FSM is not in IDLE
- done  out  1  one-cycle pulse when the last word has been written
- err  out  1  sticky illegal-mnemonic flag; cleared on start

Behaviour:
- Reset values: req_ready=0, mem_valid=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0; FSM state IDLE; both counters 0.
- FSM states IDLE, RUN, DRAIN:
  - IDLE -> RUN on start with count != 0. This latches the address counter from base_addr, loads the remaining counter from count and clears err.
  - start with count == 0: done pulses the next cycle and the FSM stays in IDLE.
  - RUN: req_ready = (!mem_valid || mem_ready) && remaining != 0.
  - On each accept: the encoded word loads the output buffer the next cycle (latency 1), mem_addr takes the address counter, the address counter increments by 4, and remaining decrements.
  - RUN -> DRAIN when remaining reaches 0.
  - DRAIN -> IDLE when the final buffered word handshakes (mem_valid && mem_ready). done pulses in that same transition cycle.
- Output buffer: mem_valid holds and the data is stable until mem_ready. An accept and a drain in the same cycle are legal, giving back-to-back throughput of 1 word/cycle.
- Address counter wraps modulo 2^ADDR_W with no error.
- Encoding:
  - R-type: {6'b0, rs, rt, rd, shamt, func}.
  - sll/srl/sra force rs=0.
  - jr forces rt, rd and shamt to 0.
  - I-type: {op, rs, rt, imm}. lui forces rs=0.
  - J-type: {op, target}.
- Opcode/func values:
  - add func 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
  - addi op 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111, j 000010, jal 000011.
- Unknown mnemonic code: the word is still written, as 32'h0000_0000 (nop); err sets and stays high.
- req_valid outside RUN is not accepted (req_ready=0); no words are dropped or duplicated.
- start while busy is ignored.
- Async reset mid-session aborts immediately. All outputs return to their reset values and the partial program is not flagged.

Decomposition:
- Package inst_pkg holds:
  - the mnemonic enum (20 codes, 5-bit),
  - opcode and func localparams,
  - an R/I/J format-select constant and a NOP constant.
- One combinational sub-module, inst_pack (mnemonic + fields -> 32-bit word + illegal flag). It is reusable by the testbench reference model.

Test Plan:
- start base=0x0000_0100, count=3; send add rd=3,rs=1,rt=2 / addi rt=1,rs=0,imm=5 / j target=0x100 -> writes 0x00221820@0x100, 0x20010005@0x104, 0x08000100@0x108; done pulses once; busy falls.
- sll rd=2,rt=1,shamt=4 with rs=7 supplied -> 0x00011100 (rs forced to 0); lw rt=4,rs=29,imm=8 -> 0x8FA40008.
- mem_ready held low 5 cycles during RUN -> mem_valid/mem_addr/mem_wdata stable; req_ready=0; no loss; resumes at 1 word/cycle.
- Illegal mnemonic code 31 -> writes 0x00000000; err=1 and remains 1 until the next start.
- count=0 start -> done pulses one cycle later with no mem_valid; a start pulse during RUN is ignored (address is not reloaded).
- rst_n low after 2 of 4 words -> all outputs return to reset values asynchronously; the next session starts cleanly at the new base_addr.

Source files
------------

// File: rtl/inst_pkg.sv
// rtl/inst_pkg.sv - mnemonic codes, opcode/func values and format selection for the instruction encoder
package inst_pkg;

    // Mnemonic codes; anything above MN_JAL is illegal and encodes as a nop.
    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,
        MN_SUB  = 5'd1,
        MN_AND  = 5'd2,
        MN_OR   = 5'd3,
        MN_XOR  = 5'd4,
        MN_SLL  = 5'd5,
        MN_SRL  = 5'd6,
        MN_SRA  = 5'd7,
        MN_JR   = 5'd8,
        MN_ADDI = 5'd9,
        MN_ANDI = 5'd10,
        MN_ORI  = 5'd11,
        MN_XORI = 5'd12,
        MN_LW   = 5'd13,
        MN_SW   = 5'd14,
        MN_BEQ  = 5'd15,
        MN_BNE  = 5'd16,
        MN_LUI  = 5'd17,
        MN_J    = 5'd18,
        MN_JAL  = 5'd19
    } mnem_t;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FMT_R    = 2'd0,
        FMT_I    = 2'd1,
        FMT_J    = 2'd2,
        FMT_NONE = 2'd3
    } fmt_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Codes are grouped R, then I, then J, so the format is a range test.
    function automatic fmt_t fmt_of(input logic [4:0] m);
        fmt_t f;
        if (m <= MN_JR)
            f = FMT_R;
        else if (m <= MN_LUI)
            f = FMT_I;
        else if (m <= MN_JAL)
            f = FMT_J;
        else
            f = FMT_NONE;
        return f;
    endfunction

endpackage

// File: rtl/inst_pack.sv
// rtl/inst_pack.sv - combinational mnemonic + fields to 32-bit MIPS word packer
module inst_pack
    import inst_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    logic [5:0] code;
    logic [4:0] rs_eff;
    logic [4:0] rt_eff;
    logic [4:0] rd_eff;
    logic [4:0] sh_eff;
    fmt_t       fmt;

    // Select opcode/func, zero the fields a mnemonic does not use, then pack by format.
    always_comb begin
        code    = 6'b000000;
        rs_eff  = rs;
        rt_eff  = rt;
        rd_eff  = rd;
        sh_eff  = shamt;
        word    = NOP;
        illegal = 1'b0;
        fmt     = fmt_of(mnem);
        case (mnem)
            MN_ADD:  code = FN_ADD;
            MN_SUB:  code = FN_SUB;
            MN_AND:  code = FN_AND;
            MN_OR:   code = FN_OR;
            MN_XOR:  code = FN_XOR;
            MN_SLL:  begin code = FN_SLL; rs_eff = 5'd0; end
            MN_SRL:  begin code = FN_SRL; rs_eff = 5'd0; end
            MN_SRA:  begin code = FN_SRA; rs_eff = 5'd0; end
            MN_JR:   begin code = FN_JR; rt_eff = 5'd0; rd_eff = 5'd0; sh_eff = 5'd0; end
            MN_ADDI: code = OP_ADDI;
            MN_ANDI: code = OP_ANDI;
            MN_ORI:  code = OP_ORI;
            MN_XORI: code = OP_XORI;
            MN_LW:   code = OP_LW;
            MN_SW:   code = OP_SW;
            MN_BEQ:  code = OP_BEQ;
            MN_BNE:  code = OP_BNE;
            MN_LUI:  begin code = OP_LUI; rs_eff = 5'd0; end
            MN_J:    code = OP_J;
            MN_JAL:  code = OP_JAL;
            default: code = 6'b000000;
        endcase
        case (fmt)
            FMT_R:   word = {6'b000000, rs_eff, rt_eff, rd_eff, sh_eff, code};
            FMT_I:   word = {code, rs_eff, rt_eff, imm};
            FMT_J:   word = {code, target};
            default: begin word = NOP; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - session-based instruction encoder streaming words into instruction memory
module inst_encoder
    import inst_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t             state;
    logic [ADDR_W-1:0]  addr_cnt;
    logic [CNT_W-1:0]   remaining;
    logic [31:0]        enc_word;
    logic               enc_illegal;
    logic               accept;
    logic               drain;

    inst_pack u_pack (
        .mnem    (mnem),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .imm     (imm),
        .target  (target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // A request can be taken when the buffer is empty or emptying this cycle.
    assign req_ready = (state == S_RUN) && (!mem_valid || mem_ready) && (remaining != '0);
    assign accept    = req_valid && req_ready;
    assign drain     = mem_valid && mem_ready;
    assign busy      = (state != S_IDLE);

    // Session FSM with address/word counters and the one-entry output buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr_cnt  <= '0;
            remaining <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (count != '0) begin
                            state     <= S_RUN;
                            addr_cnt  <= base_addr & ~ADDR_W'(3);
                            remaining <= count;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        mem_valid <= 1'b1;
                        mem_wdata <= enc_word;
                        mem_addr  <= addr_cnt;
                        addr_cnt  <= addr_cnt + ADDR_W'(4);
                        remaining <= remaining - CNT_W'(1);
                        if (enc_illegal)
                            err <= 1'b1;
                        if (remaining == CNT_W'(1))
                            state <= S_DRAIN;
                    end else if (drain) begin
                        mem_valid <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (drain) begin
                        mem_valid <= 1'b0;
                        state     <= S_IDLE;
                        done      <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - randomized self-checking bench for inst_encoder
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [9:0]  count = 10'd0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  mnem = 5'd0;
    logic [4:0]  rs = 5'd0;
    logic [4:0]  rt = 5'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  shamt = 5'd0;
    logic [15:0] imm = 16'h0;
    logic [25:0] target = 26'h0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt = 0;
    int chk_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    bit rand_bp = 1'b0;
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];

    int unsigned rfunc[9] = '{32, 34, 36, 37, 38, 0, 2, 3, 8};
    int unsigned iop[9]   = '{8, 12, 13, 14, 35, 43, 4, 5, 15};
    int unsigned jop[2]   = '{2, 3};

    inst_encoder #(.ADDR_W(32), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .req_valid(req_valid), .req_ready(req_ready), .mnem(mnem), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .imm(imm), .target(target), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && mem_valid && mem_ready) obs_q.push_back({mem_addr, mem_wdata});
        if (rst_n && done) done_cnt++;
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            mem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Returns {illegal, word}, built field by field from the instruction tables.
    function automatic logic [32:0] ref_enc(input int unsigned m, input int unsigned r_s, input int unsigned r_t,
                                            input int unsigned r_d, input int unsigned sh, input int unsigned im,
                                            input int unsigned tg);
        int unsigned w;
        if (m <= 8) begin
            if (m >= 5 && m <= 7) r_s = 0;
            if (m == 8) begin r_t = 0; r_d = 0; sh = 0; end
            w = (r_s << 21) | (r_t << 16) | (r_d << 11) | (sh << 6) | rfunc[m];
            return {1'b0, w};
        end
        if (m <= 17) begin
            if (m == 17) r_s = 0;
            w = (iop[m-9] << 26) | (r_s << 21) | (r_t << 16) | im;
            return {1'b0, w};
        end
        if (m <= 19) begin
            w = (jop[m-18] << 26) | tg;
            return {1'b0, w};
        end
        return {1'b1, 32'h0};
    endfunction

    task automatic start_session(input logic [31:0] b, input int c);
        base_addr = b;
        count = 10'(c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_req(input int unsigned m, input int unsigned r_s, input int unsigned r_t,
                            input int unsigned r_d, input int unsigned sh, input int unsigned im,
                            input int unsigned tg);
        mnem = m[4:0]; rs = r_s[4:0]; rt = r_t[4:0]; rd = r_d[4:0]; shamt = sh[4:0];
        imm = im[15:0]; target = tg[25:0];
        req_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk); #1;
                req_valid = 1'b0;
                return;
            end
        end
        chk_cnt++;
        $display("FAIL send_timeout: req_ready stayed 0 for 300 cycles, expected an accept");
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (!busy) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk_cnt++;
        $display("FAIL %s_idle_timeout: busy stayed 1 for 500 cycles, expected 0", nm);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b expected 0", req_ready); else pass_cnt++;
        chk_cnt++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid: got %b expected 0", mem_valid); else pass_cnt++;
        chk_cnt++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h expected 0", mem_addr); else pass_cnt++;
        chk_cnt++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h expected 0", mem_wdata); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b expected 0", done); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL rst_err: got %b expected 0", err); else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [63:0] want[3];
        int d0;
        want[0] = {32'h100, 32'h00221820};
        want[1] = {32'h104, 32'h20010005};
        want[2] = {32'h108, 32'h08000100};
        obs_q.delete();
        d0 = done_cnt;
        start_session(32'h100, 3);
        send_req(0, 1, 2, 3, 0, 0, 0);
        send_req(9, 0, 1, 0, 0, 5, 0);
        send_req(18, 0, 0, 0, 0, 0, 32'h100);
        wait_idle("basic");
        chk_cnt++; if (obs_q.size() !== 3) $display("FAIL basic_count: got %0d words expected 3", obs_q.size()); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if (obs_q[i] !== want[i]) $display("FAIL basic_word%0d: got %h expected %h", i, obs_q[i], want[i]);
            else pass_cnt++;
        end
        chk_cnt++; if (done_cnt - d0 !== 1) $display("FAIL basic_done: got %0d pulses expected 1", done_cnt - d0); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done_width: got %b expected 0", done); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (err !== 1'b0) $display("FAIL basic_err: got %b expected 0", err); else pass_cnt++;
    endtask

    task automatic test_fields();
        obs_q.delete();
        start_session(32'h202, 2);
        send_req(5, 7, 1, 2, 4, 0, 0);
        send_req(13, 29, 4, 0, 0, 8, 0);
        wait_idle("fields");
        chk_cnt++; if (obs_q.size() !== 2) $display("FAIL fields_count: got %0d expected 2", obs_q.size()); else pass_cnt++;
        chk_cnt++; if (obs_q[0] !== {32'h200, 32'h00011100}) $display("FAIL fields_sll: got %h expected %h", obs_q[0], {32'h200, 32'h00011100}); else pass_cnt++;
        chk_cnt++; if (obs_q[1] !== {32'h204, 32'h8FA40008}) $display("FAIL fields_lw: got %h expected %h", obs_q[1], {32'h204, 32'h8FA40008}); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int unsigned f[6][7];
        logic [32:0] ex;
        logic [31:0] snap_a, snap_d;
        int c0, c1;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            f[i][0] = $urandom_range(0, 19);
            for (int k = 1; k < 5; k++) f[i][k] = $urandom_range(0, 31);
            f[i][5] = $urandom_range(0, 65535);
            f[i][6] = $urandom_range(0, 32'h3FFFFFF);
            ex = ref_enc(f[i][0], f[i][1], f[i][2], f[i][3], f[i][4], f[i][5], f[i][6]);
            exp_q.push_back({32'h1000 + 32'(4 * i), ex[31:0]});
        end
        start_session(32'h1000, 6);
        send_req(f[0][0], f[0][1], f[0][2], f[0][3], f[0][4], f[0][5], f[0][6]);
        send_req(f[1][0], f[1][1], f[1][2], f[1][3], f[1][4], f[1][5], f[1][6]);
        mem_ready = 1'b0;
        mnem = f[2][0][4:0]; rs = f[2][1][4:0]; rt = f[2][2][4:0]; rd = f[2][3][4:0];
        shamt = f[2][4][4:0]; imm = f[2][5][15:0]; target = f[2][6][25:0];
        req_valid = 1'b1;
        @(negedge clk);
        snap_a = mem_addr; snap_d = mem_wdata;
        chk_cnt++; if (snap_a !== 32'h1004) $display("FAIL bp_held_addr: got %h expected 00001004", snap_a); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk_cnt++; if (mem_valid !== 1'b1) $display("FAIL bp_valid_c%0d: got %b expected 1", i, mem_valid); else pass_cnt++;
            chk_cnt++; if (mem_addr !== snap_a) $display("FAIL bp_addr_c%0d: got %h expected %h", i, mem_addr, snap_a); else pass_cnt++;
            chk_cnt++; if (mem_wdata !== snap_d) $display("FAIL bp_data_c%0d: got %h expected %h", i, mem_wdata, snap_d); else pass_cnt++;
            chk_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_req_ready_c%0d: got %b expected 0", i, req_ready); else pass_cnt++;
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        send_req(f[2][0], f[2][1], f[2][2], f[2][3], f[2][4], f[2][5], f[2][6]);
        send_req(f[3][0], f[3][1], f[3][2], f[3][3], f[3][4], f[3][5], f[3][6]);
        c0 = cyc;
        send_req(f[4][0], f[4][1], f[4][2], f[4][3], f[4][4], f[4][5], f[4][6]);
        send_req(f[5][0], f[5][1], f[5][2], f[5][3], f[5][4], f[5][5], f[5][6]);
        c1 = cyc;
        wait_idle("bp");
        chk_cnt++; if (c1 - c0 !== 2) $display("FAIL bp_throughput: got %0d cycles for 2 words expected 2", c1 - c0); else pass_cnt++;
        chk_cnt++; if (obs_q.size() !== 6) $display("FAIL bp_count: got %0d expected 6", obs_q.size()); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            chk_cnt++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL bp_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        obs_q.delete();
        start_session(32'h40, 2);
        send_req(31, 3, 4, 5, 6, 16'hBEEF, 0);
        chk_cnt++; if (err !== 1'b1) $display("FAIL ill_err_set: got %b expected 1", err); else pass_cnt++;
        send_req(1, 4, 5, 6, 0, 0, 0);
        wait_idle("illegal");
        chk_cnt++; if (obs_q[0] !== {32'h40, 32'h0}) $display("FAIL ill_nop: got %h expected %h", obs_q[0], {32'h40, 32'h0}); else pass_cnt++;
        chk_cnt++; if (obs_q[1] !== {32'h44, 32'h00853022}) $display("FAIL ill_next: got %h expected %h", obs_q[1], {32'h44, 32'h00853022}); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if (err !== 1'b1) $display("FAIL ill_err_sticky: got %b expected 1", err); else pass_cnt++;
        start_session(32'h80, 1);
        chk_cnt++; if (err !== 1'b0) $display("FAIL ill_err_clear: got %b expected 0", err); else pass_cnt++;
        send_req(0, 1, 1, 1, 0, 0, 0);
        wait_idle("illegal2");
        chk_cnt++; if (err !== 1'b0) $display("FAIL ill_err_stays_clear: got %b expected 0", err); else pass_cnt++;
    endtask

    task automatic test_zero_and_ignored();
        int d0;
        obs_q.delete();
        start_session(32'h500, 0);
        @(negedge clk);
        chk_cnt++; if (done !== 1'b1) $display("FAIL zero_done: got %b expected 1", done); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (mem_valid !== 1'b0) $display("FAIL zero_mem_valid: got %b expected 0", mem_valid); else pass_cnt++;
        @(posedge clk); #1;
        @(negedge clk);
        chk_cnt++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b expected 0", done); else pass_cnt++;
        @(posedge clk); #1;
        d0 = done_cnt;
        obs_q.delete();
        start_session(32'h400, 3);
        send_req(2, 1, 2, 3, 0, 0, 0);
        start_session(32'h800, 5);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL ign_busy: got %b expected 1", busy); else pass_cnt++;
        send_req(3, 1, 2, 3, 0, 0, 0);
        send_req(4, 1, 2, 3, 0, 0, 0);
        wait_idle("ignored");
        chk_cnt++; if (obs_q.size() !== 3) $display("FAIL ign_count: got %0d expected 3", obs_q.size()); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            chk_cnt++;
            if (obs_q[i][63:32] !== 32'h400 + 32'(4 * i)) $display("FAIL ign_addr%0d: got %h expected %h", i, obs_q[i][63:32], 32'h400 + 32'(4 * i));
            else pass_cnt++;
        end
        chk_cnt++; if (done_cnt - d0 !== 1) $display("FAIL ign_done: got %0d expected 1", done_cnt - d0); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int d0;
        logic [32:0] e0, e1;
        start_session(32'h2000, 4);
        send_req(0, 1, 2, 3, 0, 0, 0);
        send_req(9, 1, 2, 0, 0, 7, 0);
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk_cnt++; if (req_ready !== 1'b0) $display("FAIL mid_req_ready: got %b expected 0", req_ready); else pass_cnt++;
        chk_cnt++; if (mem_valid !== 1'b0) $display("FAIL mid_mem_valid: got %b expected 0", mem_valid); else pass_cnt++;
        chk_cnt++; if (mem_addr !== 32'h0) $display("FAIL mid_mem_addr: got %h expected 0", mem_addr); else pass_cnt++;
        chk_cnt++; if (mem_wdata !== 32'h0) $display("FAIL mid_mem_wdata: got %h expected 0", mem_wdata); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL mid_done_err: got %b%b expected 00", done, err); else pass_cnt++;
        d0 = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_cnt++; if (done_cnt !== d0) $display("FAIL mid_no_done: got %0d pulses expected 0", done_cnt - d0); else pass_cnt++;
        obs_q.delete();
        e0 = ref_enc(10, 5, 6, 0, 0, 16'h00FF, 0);
        e1 = ref_enc(19, 0, 0, 0, 0, 0, 26'h12345);
        start_session(32'h3004, 2);
        send_req(10, 5, 6, 0, 0, 16'h00FF, 0);
        send_req(19, 0, 0, 0, 0, 0, 26'h12345);
        wait_idle("mid");
        chk_cnt++; if (obs_q.size() !== 2) $display("FAIL mid_next_count: got %0d expected 2", obs_q.size()); else pass_cnt++;
        chk_cnt++; if (obs_q[0] !== {32'h3004, e0[31:0]}) $display("FAIL mid_next0: got %h expected %h", obs_q[0], {32'h3004, e0[31:0]}); else pass_cnt++;
        chk_cnt++; if (obs_q[1] !== {32'h3008, e1[31:0]}) $display("FAIL mid_next1: got %h expected %h", obs_q[1], {32'h3008, e1[31:0]}); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [32:0] ex;
        logic err_exp;
        int n, d0;
        int unsigned m, a, b, c, s, im, tg;
        rand_bp = 1'b1;
        for (int sess = 0; sess < 6; sess++) begin
            addr = (sess == 0) ? 32'hFFFF_FFFA : 32'($urandom);
            n = (sess == 0) ? 4 : $urandom_range(1, 12);
            obs_q.delete(); exp_q.delete();
            err_exp = 1'b0;
            d0 = done_cnt;
            start_session(addr, n);
            addr = addr & ~32'h3;
            for (int i = 0; i < n; i++) begin
                m = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 19);
                a = $urandom_range(0, 31); b = $urandom_range(0, 31);
                c = $urandom_range(0, 31); s = $urandom_range(0, 31);
                im = $urandom_range(0, 65535); tg = $urandom_range(0, 32'h3FFFFFF);
                ex = ref_enc(m, a, b, c, s, im, tg);
                exp_q.push_back({addr, ex[31:0]});
                err_exp = err_exp | ex[32];
                addr = addr + 32'd4;
                send_req(m, a, b, c, s, im, tg);
            end
            wait_idle("rand");
            chk_cnt++; if (obs_q.size() !== exp_q.size()) $display("FAIL rand%0d_count: got %0d expected %0d", sess, obs_q.size(), exp_q.size()); else pass_cnt++;
            for (int i = 0; i < exp_q.size(); i++) begin
                chk_cnt++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL rand%0d_word%0d: got %h expected %h", sess, i, obs_q[i], exp_q[i]);
                else pass_cnt++;
            end
            chk_cnt++; if (err !== err_exp) $display("FAIL rand%0d_err: got %b expected %b", sess, err, err_exp); else pass_cnt++;
            chk_cnt++; if (done_cnt - d0 !== 1) $display("FAIL rand%0d_done: got %0d expected 1", sess, done_cnt - d0); else pass_cnt++;
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;
        mem_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fields();
        test_backpressure();
        test_illegal();
        test_zero_and_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
